sub_cmp_pipe: RTL and testbench
===============================

Name: sub_cmp_pipe

Overview:
- Elastic two-stage pipeline wrapped around the SubVZ subtractor. Registers operands, computes S = A - B - CI, and registers the result together with a decoded flag set (N, Z, V, signed-LT) and an optional saturated result.
- Sits between the operand-issue logic and the flag/compare consumers, such as branch resolve and min/max.
- Accumulates a sticky overflow flag.

Parameters:
- width, 8, operand/result word width, minimum 2.
- speed, lau_pkg::FAST, passed unchanged to the internal SubVZ.

Ports:
- clk_i  input  1  clock, all logic on the rising edge
- rst_i  input  1  synchronous reset, active-high
- a_i  input  width  minuend, two's complement
- b_i  input  width  subtrahend
- ci_i  input  1  borrow-in, subtracted
- sat_i  input  1  saturate this transaction on overflow
- valid_i  input  1  input transaction valid
- ready_o  output  1  input stage can accept
- res_o  output  width  result, saturated if requested
- n_o  output  1  sign bit of the unsaturated difference
- z_o  output  1  unsaturated difference equals 0
- v_o  output  1  two's-complement overflow
- lt_o  output  1  signed (A - B - CI) < 0
- valid_o  output  1  output transaction valid
- ready_i  input  1  downstream accepts
- vsticky_o  output  1  sticky overflow
- clr_sticky_i  input  1  clear the sticky flag

Behaviour:
- Reset (rst_i high at an edge): stage-1 valid = 0, stage-2 valid = 0, vsticky_o = 0, res_o/n_o/z_o/v_o/lt_o = 0.
  - Reset mid-operation discards all in-flight transactions. Nothing is emitted afterwards.
  - ready_o is 0 while rst_i is high.
- Handshake: a transfer occurs on a cycle where valid && ready. Producers must hold data stable while valid && !ready.
  - valid_o must never drop without a transfer.
  - res_o and flags hold stable while valid_o && !ready_i.
- Stage 1 (operand register):
  - Captures a_i, b_i, ci_i, sat_i on an input transfer.
  - s1_ready = !s1_valid || s2_ready.
  - ready_o = s1_ready (combinational from ready_i; no skid buffer).
- Combinational between stages: SubVZ on the stage-1 registers.
- Stage 2 (result register):
  - s2_ready = !valid_o || ready_i.
  - Loads when s1_valid && s2_ready.
  - s1_valid clears on move unless refilled in the same cycle.
- Latency: 2 cycles from input transfer to valid_o, with no stall. Throughput is 1 transaction/cycle when ready_i is held high.
- Flag definitions (D = width-bit difference A - B - CI):
  - n = D[width-1].
  - v = SubVZ V.
  - lt = n ^ v.
  - z = (D == 0), correct for both ci values. Use SubVZ Z only when ci = 0; otherwise compare D to 0.
- Saturation (only when sat && v):
  - A[width-1] = 0 → res = 2^(width-1) - 1 (MAX).
  - A[width-1] = 1 → res = 2^(width-1) (MIN pattern).
  - Otherwise res = D.
  - n, z, v, lt always describe the unsaturated D.
- Sticky flag:
  - Set on an output transfer (valid_o && ready_i) with v_o = 1.
  - Cleared by clr_sticky_i.
  - If set and clear coincide, set wins.
  - Updates one cycle after the event.
- Ordering: strict FIFO order; no transaction is dropped or duplicated under any ready_i pattern.
- Boundary cases:
  - Back-to-back input with ready_i = 0: pipeline fills (2 held transactions), then ready_o = 0.
  - ready_i rising with valid_i high: both stages advance in the same cycle.

Test Plan:
1. Reset: assert rst_i 3 cycles with valid_i = 1 → valid_o = 0, ready_o = 0, vsticky_o = 0, res_o = 0x00. First accept occurs on the cycle after rst_i falls.
2. Basic subtract (width = 8): a = 0x05, b = 0x03, ci = 0 at cycle t → at t+2, valid_o = 1, res = 0x02, n/z/v/lt = 0/0/0/0. Then a = 0x03, b = 0x05 → res = 0xFE, n = 1, lt = 1, v = 0.
3. Overflow/saturation:
   - a = 0x80, b = 0x01, sat = 0 → res = 0x7F, v = 1, n = 0, lt = 1, and vsticky_o = 1 on the cycle after transfer.
   - Same operands with sat = 1 → res = 0x80.
   - a = 0x7F, b = 0xFF, sat = 1 → res = 0x7F, v = 1.
4. Zero flag with borrow: a = 0x07, b = 0x07, ci = 0 → z = 1, res = 0x00. Then a = 0x07, b = 0x06, ci = 1 → z = 1, res = 0x00. Then a = 0x00, b = 0x00, ci = 1 → res = 0xFF, z = 0, lt = 1.
5. Backpressure: stream 4 transactions (values 1..4 minus 0) with ready_i = 0 for 6 cycles → ready_o falls after 2 accepts and valid_o/res_o hold 0x01 stable. Release ready_i → outputs 1, 2, 3, 4 on consecutive cycles, in order, none lost.
6. Sticky and reset flush:
   - clr_sticky_i asserted in the same cycle as an overflowing output transfer → vsticky_o = 1.
   - clr alone → 0 next cycle.
   - rst_i pulsed with 2 transactions in flight → neither is ever emitted.

Source files
------------

// File: rtl/lau_pkg.sv
// Shared options for the arithmetic-unit blocks.
package lau_pkg;

    // FAST uses the tool's native subtractor; SMALL builds an explicit ripple-borrow chain.
    typedef enum logic [0:0] {
        FAST  = 1'b0,
        SMALL = 1'b1
    } speed_e;

endpackage

// File: rtl/SubVZ.sv
// Combinational subtractor S = A - B - CI with two's-complement overflow and an A == B zero flag.
module SubVZ #(
    parameter int              width = 8,
    parameter lau_pkg::speed_e speed = lau_pkg::FAST
) (
    input  logic [width-1:0] a_i,
    input  logic [width-1:0] b_i,
    input  logic             ci_i,
    output logic [width-1:0] s_o,
    output logic             v_o,
    output logic             z_o
);

    generate
        if (speed == lau_pkg::FAST) begin : g_fast
            assign s_o = a_i - b_i - {{(width-1){1'b0}}, ci_i};
        end else begin : g_ripple
            logic [width-1:0] bw;
            assign bw[0] = ci_i;
            for (genvar i = 0; i < width; i++) begin : g_bit
                assign s_o[i] = a_i[i] ^ b_i[i] ^ bw[i];
                if (i < width - 1) begin : g_borrow
                    assign bw[i+1] = (~a_i[i] & b_i[i]) | (~(a_i[i] ^ b_i[i]) & bw[i]);
                end
            end
        end
    endgenerate

    // Overflow: operand signs differ and the result sign differs from the minuend.
    assign v_o = (a_i[width-1] ^ b_i[width-1]) & (a_i[width-1] ^ s_o[width-1]);

    // Only equals (S == 0) when ci_i is 0; callers handle the borrow case themselves.
    assign z_o = (a_i == b_i);

endmodule

// File: rtl/sub_cmp_pipe.sv
// Elastic two-stage subtract/compare pipeline around SubVZ: operand register, result+flag register,
// optional saturation and a sticky overflow flag.
//
// Handshake (both sides): a transfer happens on a rising edge where valid && ready. The producer holds
// its payload stable while valid && !ready; valid_o never drops and res_o/flags never change until the
// transfer completes. ready_o is combinational from ready_i and forced low while rst_i is high.
module sub_cmp_pipe #(
    parameter int              width = 8,
    parameter lau_pkg::speed_e speed = lau_pkg::FAST
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [width-1:0] a_i,
    input  logic [width-1:0] b_i,
    input  logic             ci_i,
    input  logic             sat_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [width-1:0] res_o,
    output logic             n_o,
    output logic             z_o,
    output logic             v_o,
    output logic             lt_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             vsticky_o,
    input  logic             clr_sticky_i
);

    localparam logic [width-1:0] SAT_MAX = {1'b0, {(width-1){1'b1}}};
    localparam logic [width-1:0] SAT_MIN = {1'b1, {(width-1){1'b0}}};

    // Stage 1: operand register
    logic             s1_valid_q, s1_valid_d;
    logic [width-1:0] a_q, a_d;
    logic [width-1:0] b_q, b_d;
    logic             ci_q, ci_d;
    logic             sat_q, sat_d;

    // Stage 2: result register
    logic             s2_valid_q, s2_valid_d;
    logic [width-1:0] res_q, res_d;
    logic             n_q, n_d;
    logic             z_q, z_d;
    logic             v_q, v_d;
    logic             lt_q, lt_d;

    logic             sticky_q, sticky_d;

    // Handshake and datapath
    logic             s1_ready;
    logic             s2_ready;
    logic             in_xfer;
    logic             out_xfer;
    logic             s2_load;
    logic [width-1:0] sub_s;
    logic             sub_v;
    logic             sub_z;
    logic             diff_zero;
    logic [width-1:0] sat_res;

    SubVZ #(
        .width (width),
        .speed (speed)
    ) u_sub (
        .a_i  (a_q),
        .b_i  (b_q),
        .ci_i (ci_q),
        .s_o  (sub_s),
        .v_o  (sub_v),
        .z_o  (sub_z)
    );

    assign s2_ready = !s2_valid_q || ready_i;
    assign s1_ready = !s1_valid_q || s2_ready;
    assign ready_o  = s1_ready && !rst_i;
    assign in_xfer  = valid_i && ready_o;
    assign out_xfer = s2_valid_q && ready_i;
    assign s2_load  = s1_valid_q && s2_ready;

    // SubVZ's zero flag ignores the borrow-in, so fall back to a direct compare when ci is set.
    assign diff_zero = ci_q ? (sub_s == '0) : sub_z;

    always_comb begin
        sat_res = sub_s;
        if (sat_q && sub_v) begin
            sat_res = a_q[width-1] ? SAT_MIN : SAT_MAX;
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        a_d        = a_q;
        b_d        = b_q;
        ci_d       = ci_q;
        sat_d      = sat_q;
        if (in_xfer) begin
            s1_valid_d = 1'b1;
            a_d        = a_i;
            b_d        = b_i;
            ci_d       = ci_i;
            sat_d      = sat_i;
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        res_d      = res_q;
        n_d        = n_q;
        z_d        = z_q;
        v_d        = v_q;
        lt_d       = lt_q;
        if (s2_load) begin
            s2_valid_d = 1'b1;
            res_d      = sat_res;
            n_d        = sub_s[width-1];
            z_d        = diff_zero;
            v_d        = sub_v;
            lt_d       = sub_s[width-1] ^ sub_v;
        end else if (out_xfer) begin
            s2_valid_d = 1'b0;
        end
    end

    // A set from an overflowing transfer takes priority over a simultaneous clear.
    always_comb begin
        sticky_d = sticky_q;
        if (out_xfer && v_q) begin
            sticky_d = 1'b1;
        end else if (clr_sticky_i) begin
            sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            ci_q       <= 1'b0;
            sat_q      <= 1'b0;
            s2_valid_q <= 1'b0;
            res_q      <= '0;
            n_q        <= 1'b0;
            z_q        <= 1'b0;
            v_q        <= 1'b0;
            lt_q       <= 1'b0;
            sticky_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            a_q        <= a_d;
            b_q        <= b_d;
            ci_q       <= ci_d;
            sat_q      <= sat_d;
            s2_valid_q <= s2_valid_d;
            res_q      <= res_d;
            n_q        <= n_d;
            z_q        <= z_d;
            v_q        <= v_d;
            lt_q       <= lt_d;
            sticky_q   <= sticky_d;
        end
    end

    assign valid_o   = s2_valid_q;
    assign res_o     = res_q;
    assign n_o       = n_q;
    assign z_o       = z_q;
    assign v_o       = v_q;
    assign lt_o      = lt_q;
    assign vsticky_o = sticky_q;

endmodule

// File: tb/tb_sub_cmp_pipe.sv
// Self-checking bench for sub_cmp_pipe: directed plan vectors plus randomized traffic, with an
// arithmetic reference model feeding an expected queue that a negedge monitor drains.
module tb_sub_cmp_pipe;

    localparam int W = 8;

    // Clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_i        = 1'b1;
    logic [W-1:0] a_i          = '0;
    logic [W-1:0] b_i          = '0;
    logic         ci_i         = 1'b0;
    logic         sat_i        = 1'b0;
    logic         valid_i      = 1'b0;
    logic         ready_i      = 1'b0;
    logic         clr_sticky_i = 1'b0;
    logic         ready_o;
    logic [W-1:0] res_o;
    logic         n_o, z_o, v_o, lt_o, valid_o, vsticky_o;

    sub_cmp_pipe #(
        .width (W),
        .speed (lau_pkg::FAST)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .a_i          (a_i),
        .b_i          (b_i),
        .ci_i         (ci_i),
        .sat_i        (sat_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .res_o        (res_o),
        .n_o          (n_o),
        .z_o          (z_o),
        .v_o          (v_o),
        .lt_o         (lt_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .vsticky_o    (vsticky_o),
        .clr_sticky_i (clr_sticky_i)
    );

    int checks   = 0;
    int failures = 0;

    // Expected entries packed as {res, n, z, v, lt}
    logic [W+3:0] exp_q[$];
    int           rdy_mode    = 0;   // 0: ready high, 1: ready low, 2: random
    bit           rnd_clr     = 1'b0;
    logic         exp_sticky  = 1'b0;
    bit           held        = 1'b0;
    logic [W+3:0] held_val    = '0;
    logic [W+3:0] got_val;
    logic [W+3:0] pop_val;
    logic         xfer_v;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model from plain signed arithmetic
    function automatic logic [W+3:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic ci, input logic sat);
        int           diff, maxv, minv;
        logic [W-1:0] d, r;
        logic         v;
        maxv = (1 << (W - 1)) - 1;
        minv = -(1 << (W - 1));
        diff = int'($signed(a)) - int'($signed(b)) - int'(ci);
        v    = (diff > maxv) || (diff < minv);
        d    = W'(diff);
        if (sat && v) r = (diff > maxv) ? W'(maxv) : W'(minv);
        else          r = d;
        return {r, d[W-1], (d == '0), v, (diff < 0)};
    endfunction

    // Downstream ready / random sticky-clear driver
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       ready_i = 1'b1;
                1:       ready_i = 1'b0;
                default: ready_i = ($urandom_range(0, 3) != 0);
            endcase
            if (rnd_clr) clr_sticky_i = ($urandom_range(0, 15) == 0);
        end
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst_i) begin
            exp_q.delete();
            exp_sticky = 1'b0;
            held       = 1'b0;
        end else begin
            check("vsticky", vsticky_o, exp_sticky);
            got_val = {res_o, n_o, z_o, v_o, lt_o};
            if (held) begin
                check("hold_valid", valid_o, 1'b1);
                check("hold_data", got_val, held_val);
            end
            xfer_v = 1'b0;
            if (valid_o === 1'b1 && ready_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_output actual=0x%0h required=no_output at %0t", got_val, $time);
                end else begin
                    pop_val = exp_q.pop_front();
                    check("result", got_val, pop_val);
                    xfer_v = pop_val[1];
                end
            end
            held     = (valid_o === 1'b1) && !ready_i;
            held_val = got_val;
            if (valid_o === 1'b1 && ready_i && xfer_v) exp_sticky = 1'b1;
            else if (clr_sticky_i)                     exp_sticky = 1'b0;
        end
    end

    // Driver: call at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci, input logic sat);
        int  budget;
        bit  took;
        budget  = 0;
        took    = 1'b0;
        a_i     = a;
        b_i     = b;
        ci_i    = ci;
        sat_i   = sat;
        valid_i = 1'b1;
        while (!took && budget < 200) begin
            @(negedge clk);
            if (ready_o) begin
                took = 1'b1;
                exp_q.push_back(ref_model(a, b, ci, sat));
            end
            budget++;
        end
        if (!took) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        valid_i = 1'b0;
    endtask

    // Returns at negedge+1 on the cycle the last expected entry is popped
    task automatic wait_drain();
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 300) begin
            @(negedge clk);
            #1;
            budget++;
        end
        check("drain_timeout", exp_q.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        // Reset with valid_i held high
        valid_i = 1'b1;
        a_i     = 8'h11;
        b_i     = 8'h22;
        repeat (3) begin
            @(negedge clk);
            check("rst_valid_o", valid_o, 1'b0);
            check("rst_ready_o", ready_o, 1'b0);
        end
        check("rst_vsticky", vsticky_o, 1'b0);
        check("rst_res", res_o, '0);
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        check("first_accept_ready", ready_o, 1'b1);
        exp_q.push_back(ref_model(8'h11, 8'h22, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        valid_i = 1'b0;

        // Basic, overflow/saturation and zero-with-borrow vectors
        send(8'h05, 8'h03, 1'b0, 1'b0);
        send(8'h03, 8'h05, 1'b0, 1'b0);
        send(8'h80, 8'h01, 1'b0, 1'b0);
        send(8'h80, 8'h01, 1'b0, 1'b1);
        send(8'h7F, 8'hFF, 1'b0, 1'b1);
        send(8'h07, 8'h07, 1'b0, 1'b0);
        send(8'h07, 8'h06, 1'b1, 1'b0);
        send(8'h00, 8'h00, 1'b1, 1'b0);
        wait_drain();
        @(negedge clk);
        check("sticky_after_ovf", vsticky_o, 1'b1);

        // Backpressure: fill both stages, hold, then release
        rdy_mode = 1;
        repeat (2) @(posedge clk);
        #1;
        fork
            begin
                for (int i = 1; i <= 4; i++) send(W'(i), 8'h00, 1'b0, 1'b0);
            end
            begin
                repeat (2) @(negedge clk);
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    check("bp_ready_o", ready_o, 1'b0);
                    check("bp_valid_o", valid_o, 1'b1);
                    check("bp_res", res_o, 8'h01);
                end
                rdy_mode = 0;
            end
        join
        wait_drain();

        // Sticky: set beats a coincident clear, then a lone clear
        @(posedge clk);
        #1;
        clr_sticky_i = 1'b1;
        send(8'h80, 8'h01, 1'b0, 1'b0);
        wait_drain();
        @(posedge clk);
        #1;
        clr_sticky_i = 1'b0;
        @(negedge clk);
        check("sticky_set_wins", vsticky_o, 1'b1);
        @(posedge clk);
        #1;
        clr_sticky_i = 1'b1;
        @(posedge clk);
        #1;
        clr_sticky_i = 1'b0;
        @(negedge clk);
        check("sticky_clr", vsticky_o, 1'b0);

        // Reset flush with two transactions in flight
        rdy_mode = 1;
        repeat (2) @(posedge clk);
        #1;
        send(8'h10, 8'h01, 1'b0, 1'b0);
        send(8'h20, 8'h01, 1'b0, 1'b0);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i    = 1'b0;
        rdy_mode = 0;
        repeat (10) begin
            @(negedge clk);
            check("flush_valid_o", valid_o, 1'b0);
        end

        // Randomized traffic with random backpressure and sticky clears
        @(posedge clk);
        #1;
        rdy_mode = 2;
        rnd_clr  = 1'b1;
        for (int n = 0; n < 300; n++) begin
            send(W'($urandom_range(0, (1 << W) - 1)), W'($urandom_range(0, (1 << W) - 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        rnd_clr = 1'b0;
        @(posedge clk);
        #2;
        clr_sticky_i = 1'b0;
        rdy_mode     = 0;
        wait_drain();
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
